// File: rtl/ysyx_24090012_rd_xbar_pkg.sv
// Shared definitions for the AXI4-Lite read crossbar and its address decoder.
package ysyx_24090012_rd_xbar_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] CLINT_BASE_DEF = 32'h0200_0000;
  localparam logic [31:0] CLINT_MASK_DEF = 32'hFFFF_0000;
  localparam logic [31:0] MEM_BASE_DEF   = 32'h8000_0000;
  localparam logic [31:0] MEM_MASK_DEF   = 32'hF800_0000;

  localparam logic SEL_MEM   = 1'b0;
  localparam logic SEL_CLINT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } xbar_state_e;

endpackage

// File: rtl/ysyx_24090012_addr_dec.sv
// Address map decoder; CLINT wins if both windows ever overlap.
module ysyx_24090012_addr_dec
  import ysyx_24090012_rd_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [31:0] CLINT_MASK = CLINT_MASK_DEF,
  parameter logic [31:0] MEM_BASE   = MEM_BASE_DEF,
  parameter logic [31:0] MEM_MASK   = MEM_MASK_DEF
) (
  input  logic [31:0] addr,
  output logic        hit_mem,
  output logic        hit_clint
);

  logic clint_match;
  logic mem_match;

  assign clint_match = ((addr & CLINT_MASK) == CLINT_BASE);
  assign mem_match   = ((addr & MEM_MASK) == MEM_BASE);

  assign hit_clint = clint_match;
  assign hit_mem   = mem_match & ~clint_match;

endmodule

// File: rtl/ysyx_24090012_rd_xbar.sv
// AXI4-Lite read crossbar: one master, memory (m0) and CLINT (m1) slaves,
// one transaction in flight, unmapped reads answered locally with DECERR.
//
// state | meaning
// IDLE  | ready for a new read address
// ADDR  | presenting latched address to the selected slave
// DATA  | waiting for the selected slave's read data
// RESP  | holding registered response until the master takes it
module ysyx_24090012_rd_xbar
  import ysyx_24090012_rd_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [31:0] CLINT_MASK = CLINT_MASK_DEF,
  parameter logic [31:0] MEM_BASE   = MEM_BASE_DEF,
  parameter logic [31:0] MEM_MASK   = MEM_MASK_DEF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,

  output logic        m0_arvalid,
  input  logic        m0_arready,
  output logic [31:0] m0_araddr,
  input  logic        m0_rvalid,
  output logic        m0_rready,
  input  logic [31:0] m0_rdata,
  input  logic [1:0]  m0_rresp,

  output logic        m1_arvalid,
  input  logic        m1_arready,
  output logic [31:0] m1_araddr,
  input  logic        m1_rvalid,
  output logic        m1_rready,
  input  logic [31:0] m1_rdata,
  input  logic [1:0]  m1_rresp
);

  xbar_state_e state_q;
  xbar_state_e state_d;

  logic [31:0] addr_r;
  logic        sel_r;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r;

  logic hit_mem;
  logic hit_clint;
  logic hit_any;
  logic sel_arready;
  logic sel_rvalid;

  ysyx_24090012_addr_dec #(
    .CLINT_BASE (CLINT_BASE),
    .CLINT_MASK (CLINT_MASK),
    .MEM_BASE   (MEM_BASE),
    .MEM_MASK   (MEM_MASK)
  ) u_addr_dec (
    .addr      (s_araddr),
    .hit_mem   (hit_mem),
    .hit_clint (hit_clint)
  );

  assign hit_any     = hit_mem | hit_clint;
  assign sel_arready = (sel_r == SEL_CLINT) ? m1_arready : m0_arready;
  assign sel_rvalid  = (sel_r == SEL_CLINT) ? m1_rvalid  : m0_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (s_arvalid)  state_d = hit_any ? ST_ADDR : ST_RESP;
      ST_ADDR: if (sel_arready) state_d = ST_DATA;
      ST_DATA: if (sel_rvalid)  state_d = ST_RESP;
      ST_RESP: if (s_rready)    state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Readies are also gated by rst so that everything reads 0 while held in reset.
  always_comb begin
    s_arready  = 1'b0;
    s_rvalid   = 1'b0;
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    m0_rready  = 1'b0;
    m1_rready  = 1'b0;
    case (state_q)
      ST_IDLE: s_arready = rst;
      ST_ADDR: begin
        m0_arvalid = (sel_r == SEL_MEM);
        m1_arvalid = (sel_r == SEL_CLINT);
      end
      ST_DATA: begin
        m0_rready = (sel_r == SEL_MEM);
        m1_rready = (sel_r == SEL_CLINT);
      end
      ST_RESP: s_rvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r  <= '0;
      sel_r   <= SEL_MEM;
      rdata_r <= '0;
      rresp_r <= RESP_OKAY;
    end else begin
      if (state_q == ST_IDLE && s_arvalid) begin
        addr_r <= s_araddr;
        sel_r  <= hit_clint ? SEL_CLINT : SEL_MEM;
        if (!hit_any) begin
          rdata_r <= '0;
          rresp_r <= RESP_DECERR;
        end
      end
      if (state_q == ST_DATA && sel_rvalid) begin
        rdata_r <= (sel_r == SEL_CLINT) ? m1_rdata : m0_rdata;
        rresp_r <= (sel_r == SEL_CLINT) ? m1_rresp : m0_rresp;
      end
    end
  end

  assign m0_araddr = addr_r;
  assign m1_araddr = addr_r;
  assign s_rdata   = rdata_r;
  assign s_rresp   = rresp_r;

endmodule

// File: tb/tb_ysyx_24090012_rd_xbar.sv
// Directed and randomized reads through the read crossbar against an address-range model.
module tb_ysyx_24090012_rd_xbar;

  logic        clk;
  logic        rst;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [1:0]  m1_rresp;

  int n_cmp  = 0;
  int n_fail = 0;

  ysyx_24090012_rd_xbar dut (
    .clk        (clk),
    .rst        (rst),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_araddr   (s_araddr),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .m0_arvalid (m0_arvalid),
    .m0_arready (m0_arready),
    .m0_araddr  (m0_araddr),
    .m0_rvalid  (m0_rvalid),
    .m0_rready  (m0_rready),
    .m0_rdata   (m0_rdata),
    .m0_rresp   (m0_rresp),
    .m1_arvalid (m1_arvalid),
    .m1_arready (m1_arready),
    .m1_araddr  (m1_araddr),
    .m1_rvalid  (m1_rvalid),
    .m1_rready  (m1_rready),
    .m1_rdata   (m1_rdata),
    .m1_rresp   (m1_rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 = unmapped, 1 = memory (m0), 2 = CLINT (m1), from the plain address ranges
  function automatic int ref_target(input logic [31:0] a);
    if (a >= 32'h0200_0000 && a <= 32'h0200_FFFF) return 2;
    if (a >= 32'h8000_0000 && a <= 32'h87FF_FFFF) return 1;
    return 0;
  endfunction

  task automatic drive_slave(input int i, input logic arr, input logic rv,
                             input logic [31:0] rd, input logic [1:0] rr);
    if (i == 1) begin
      m0_arready = arr; m0_rvalid = rv; m0_rdata = rd; m0_rresp = rr;
    end else begin
      m1_arready = arr; m1_rvalid = rv; m1_rdata = rd; m1_rresp = rr;
    end
  endtask

  function automatic logic [31:0] mon_arv(input int i);
    return 32'(i == 1 ? m0_arvalid : m1_arvalid);
  endfunction

  function automatic logic [31:0] mon_rrdy(input int i);
    return 32'(i == 1 ? m0_rready : m1_rready);
  endfunction

  function automatic logic [31:0] mon_addr(input int i);
    return (i == 1) ? m0_araddr : m1_araddr;
  endfunction

  task automatic chk_all_zero(input string ph);
    chk({ph, "_s_arready"}, 32'(s_arready), 32'd0);
    chk({ph, "_s_rvalid"},  32'(s_rvalid), 32'd0);
    chk({ph, "_s_rdata"},   s_rdata, 32'd0);
    chk({ph, "_s_rresp"},   32'(s_rresp), 32'd0);
    chk({ph, "_m0_arvalid"}, 32'(m0_arvalid), 32'd0);
    chk({ph, "_m1_arvalid"}, 32'(m1_arvalid), 32'd0);
    chk({ph, "_m0_rready"},  32'(m0_rready), 32'd0);
    chk({ph, "_m1_rready"},  32'(m1_rready), 32'd0);
    chk({ph, "_m0_araddr"},  m0_araddr, 32'd0);
    chk({ph, "_m1_araddr"},  m1_araddr, 32'd0);
  endtask

  // One full read; every cycle is checked, so the step count fixes the latency.
  task automatic do_read(input logic [31:0] addr, input int ar_stall, input int r_stall,
                         input int rr_hold, input logic [31:0] rdata, input logic [1:0] rresp,
                         input logic nxt_arvalid, input logic [31:0] nxt_addr);
    int tgt;
    int oth;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    tgt = ref_target(addr);
    oth = (tgt == 1) ? 2 : 1;
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = addr; s_rready = 1'b0;
    drive_slave(1, 1'b0, 1'b0, 32'h0, 2'b00);
    drive_slave(2, 1'b0, 1'b0, 32'h0, 2'b00);
    #1;
    chk("idle_s_arready", 32'(s_arready), 32'd1);
    chk("idle_s_rvalid", 32'(s_rvalid), 32'd0);
    chk("idle_m_arvalid", 32'({m1_arvalid, m0_arvalid}), 32'd0);
    if (tgt == 0) begin
      exp_d = 32'h0;
      exp_r = 2'b11;
    end else begin
      exp_d = rdata;
      exp_r = rresp;
      for (int k = 0; k <= ar_stall; k++) begin
        @(negedge clk);
        s_arvalid = 1'($urandom_range(0, 1));
        s_araddr  = $urandom;
        drive_slave(tgt, (k == ar_stall), 1'b0, $urandom, 2'b00);
        drive_slave(oth, 1'($urandom_range(0, 1)), 1'b0, $urandom, 2'b00);
        #1;
        chk("addr_tgt_arvalid", mon_arv(tgt), 32'd1);
        chk("addr_oth_arvalid", mon_arv(oth), 32'd0);
        chk("addr_tgt_araddr", mon_addr(tgt), addr);
        chk("addr_s_arready", 32'(s_arready), 32'd0);
        chk("addr_s_rvalid", 32'(s_rvalid), 32'd0);
        chk("addr_rready", 32'({m1_rready, m0_rready}), 32'd0);
      end
      for (int k = 0; k <= r_stall; k++) begin
        @(negedge clk);
        drive_slave(tgt, 1'b0, (k == r_stall), (k == r_stall) ? rdata : $urandom,
                    (k == r_stall) ? rresp : 2'($urandom_range(0, 3)));
        drive_slave(oth, 1'b0, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)));
        #1;
        chk("data_tgt_rready", mon_rrdy(tgt), 32'd1);
        chk("data_oth_rready", mon_rrdy(oth), 32'd0);
        chk("data_arvalid", 32'({m1_arvalid, m0_arvalid}), 32'd0);
        chk("data_s_rvalid", 32'(s_rvalid), 32'd0);
        chk("data_s_arready", 32'(s_arready), 32'd0);
      end
    end
    for (int k = 0; k <= rr_hold; k++) begin
      @(negedge clk);
      drive_slave(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 2'b01);
      drive_slave(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 2'b01);
      s_rready  = (k == rr_hold);
      s_arvalid = nxt_arvalid;
      s_araddr  = nxt_addr;
      #1;
      chk("resp_s_rvalid", 32'(s_rvalid), 32'd1);
      chk("resp_s_rdata", s_rdata, exp_d);
      chk("resp_s_rresp", 32'(s_rresp), 32'(exp_r));
      chk("resp_s_arready", 32'(s_arready), 32'd0);
      chk("resp_m_arvalid", 32'({m1_arvalid, m0_arvalid}), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_arvalid = 1'b0; s_araddr = 32'h0; s_rready = 1'b0;
    m0_arready = 1'b0; m0_rvalid = 1'b0; m0_rdata = 32'h0; m0_rresp = 2'b00;
    m1_arready = 1'b0; m1_rvalid = 1'b0; m1_rdata = 32'h0; m1_rresp = 2'b00;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // CLINT zero-wait read, then memory with stalls
    do_read(32'h0200_0008, 0, 0, 0, 32'h0000_1234, 2'b00, 1'b0, 32'h0);
    do_read(32'h8000_0100, 2, 3, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0);
    // unmapped
    do_read(32'h1000_0000, 0, 0, 0, 32'h0, 2'b00, 1'b0, 32'h0);
    // master stalls response while a second address waits
    do_read(32'h8000_0200, 0, 1, 4, 32'hCAFE_0001, 2'b00, 1'b1, 32'h0200_0010);
    do_read(32'h0200_0010, 1, 0, 0, 32'h0000_0077, 2'b00, 1'b0, 32'h0);
    // SLVERR pass-through
    do_read(32'h8000_0300, 0, 0, 0, 32'h0, 2'b10, 1'b0, 32'h0);
    // window edges
    do_read(32'h87FF_FFFC, 0, 0, 0, 32'h1111_2222, 2'b00, 1'b0, 32'h0);
    do_read(32'h8800_0000, 0, 0, 1, 32'h0, 2'b00, 1'b0, 32'h0);
    do_read(32'h0201_0000, 0, 0, 0, 32'h0, 2'b00, 1'b0, 32'h0);
    do_read(32'h0200_FFFC, 0, 2, 0, 32'h3333_4444, 2'b11, 1'b0, 32'h0);

    // reset while in DATA
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = 32'h8000_0040; s_rready = 1'b0;
    drive_slave(1, 1'b0, 1'b0, 32'h0, 2'b00);
    drive_slave(2, 1'b0, 1'b0, 32'h0, 2'b00);
    @(negedge clk);
    s_arvalid = 1'b0; m0_arready = 1'b1;
    #1 chk("rst_seq_m0_arvalid", 32'(m0_arvalid), 32'd1);
    @(negedge clk);
    m0_arready = 1'b0;
    #1 chk("rst_seq_m0_rready", 32'(m0_rready), 32'd1);
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_in_data");
    @(negedge clk);
    m0_rvalid = 1'b1; m0_rdata = 32'hBAD0_BAD0;
    #1 chk_all_zero("rst_held");
    @(negedge clk);
    rst = 1'b1;
    do_read(32'h0200_000C, 0, 0, 0, 32'h0000_5678, 2'b00, 1'b0, 32'h0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 2))
        0: a = 32'h0200_0000 + 32'($urandom_range(0, 32'hFFFF));
        1: a = 32'h8000_0000 + 32'($urandom_range(0, 32'h07FF_FFFF));
        default: a = $urandom;
      endcase
      do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
              $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
    end

    @(negedge clk);
    s_arvalid = 1'b0; s_rready = 1'b0;
    #1 chk("final_idle_arready", 32'(s_arready), 32'd1);
    chk("final_s_rvalid", 32'(s_rvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
